// File: rtl/mpu_store.sv
// Streams a matrix register out of the MPU register file in row-major order over valid/ready.
// First element is valid 3 cycles after ack; a 2-entry FIFO absorbs backpressure and stalls reads when full.
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_en_in,
  input  logic [MATRIX_REG_SIZE-1:0] mem_store_addr_in,
  output logic                       mem_store_ack_out,
  output logic                       mem_store_error_out,
  output logic                       mem_store_busy_out,
  output logic                       mem_store_valid_out,
  input  logic                       mem_store_ready_in,
  output logic [FP-1:0]              mem_store_element_out,
  output logic                       mem_store_last_out,
  output logic [MBITS:0]             mem_m_store_size_out,
  output logic [NBITS:0]             mem_n_store_size_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  input  logic [MBITS:0]             reg_m_store_size_in,
  input  logic [NBITS:0]             reg_n_store_size_in,
  output logic                       reg_store_en_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [FP-1:0]              reg_store_element_in
);

  typedef enum logic [1:0] {
    STORE_IDLE  = 2'd0,
    STORE_READ  = 2'd1,
    STORE_DRAIN = 2'd2
  } state_t;

  localparam logic [MBITS:0] L_M_MAX = M[MBITS:0];
  localparam logic [NBITS:0] L_N_MAX = N[NBITS:0];
  localparam logic [MBITS:0] L_M_ONE = {{MBITS{1'b0}}, 1'b1};
  localparam logic [NBITS:0] L_N_ONE = {{NBITS{1'b0}}, 1'b1};

  state_t                     r_state;
  logic                       r_error;
  logic [MATRIX_REG_SIZE-1:0] r_addr;
  logic [MBITS:0]             r_m;
  logic [NBITS:0]             r_n;
  logic [MBITS:0]             r_row;
  logic [NBITS:0]             r_col;
  logic                       r_inflight;
  logic                       r_inflight_last;
  logic [FP-1:0]              r_fifo_dat [2];
  logic                       r_fifo_last [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;

  logic       w_busy;
  logic       w_size_bad;
  logic       w_accept;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic [2:0] w_limit;
  logic       w_issue;
  logic       w_col_wrap;
  logic       w_last_issue;
  logic       w_head_last;

  assign w_busy     = (r_state != STORE_IDLE);
  assign w_size_bad = (reg_m_store_size_in == '0) || (reg_n_store_size_in == '0) ||
                      (reg_m_store_size_in > L_M_MAX) || (reg_n_store_size_in > L_N_MAX);
  assign w_accept   = !rst && (r_state == STORE_IDLE) && store_en_in && !w_size_bad;

  assign w_pop       = (r_count != 2'd0) && mem_store_ready_in;
  assign w_push      = r_inflight;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // A read only issues when its data is guaranteed a FIFO slot on return,
  // counting the element leaving this cycle as freed space.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_limit      = 3'd2 + {2'b00, w_pop};
  assign w_issue      = !rst && (r_state == STORE_READ) && (w_occ < w_limit);
  assign w_col_wrap   = (r_col == (r_n - L_N_ONE));
  assign w_last_issue = w_issue && w_col_wrap && (r_row == (r_m - L_M_ONE));

  assign mem_store_ack_out     = w_accept;
  assign mem_store_error_out   = r_error;
  assign mem_store_busy_out    = w_busy;
  assign mem_store_valid_out   = (r_count != 2'd0);
  assign mem_store_element_out = r_fifo_dat[r_rd_ptr];
  assign mem_store_last_out    = (r_count != 2'd0) && w_head_last;
  assign mem_m_store_size_out  = w_busy ? r_m : '0;
  assign mem_n_store_size_out  = w_busy ? r_n : '0;
  assign reg_store_addr_out    = w_busy ? r_addr : mem_store_addr_in;
  assign reg_store_en_out      = w_issue;
  assign reg_i_store_loc_out   = w_issue ? r_row : '0;
  assign reg_j_store_loc_out   = w_issue ? r_col : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= STORE_IDLE;
      r_error         <= 1'b0;
      r_addr          <= '0;
      r_m             <= '0;
      r_n             <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        r_fifo_dat[k]  <= '0;
        r_fifo_last[k] <= 1'b0;
      end
    end else begin
      case (r_state)
        STORE_IDLE: begin
          if (store_en_in) begin
            if (w_size_bad) begin
              r_error <= 1'b1;
            end else begin
              r_error <= 1'b0;
              r_addr  <= mem_store_addr_in;
              r_m     <= reg_m_store_size_in;
              r_n     <= reg_n_store_size_in;
              r_row   <= '0;
              r_col   <= '0;
              r_state <= STORE_READ;
            end
          end
        end
        STORE_READ: begin
          if (w_issue) begin
            if (w_col_wrap) begin
              r_col <= '0;
              r_row <= r_row + L_M_ONE;
            end else begin
              r_col <= r_col + L_N_ONE;
            end
            if (w_last_issue) begin
              r_state <= STORE_DRAIN;
            end
          end
        end
        STORE_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= STORE_IDLE;
          end
        end
        default: r_state <= STORE_IDLE;
      endcase

      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;

      if (w_push) begin
        r_fifo_dat[r_wr_ptr]  <= reg_store_element_in;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
